// File: rtl/decoder_24_seq.sv
// rtl/decoder_24_seq.sv - 2:4 one-hot decoder with code FIFO and programmable hold/gap stretching.
module decoder_24_seq #(
   parameter int HOLD_CYC = 4,
   parameter int GAP_CYC  = 1,
   parameter int DEPTH    = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               in_code,
   output logic [3:0]               o,
   output logic                     o_valid,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   fifo_cnt
);

   localparam int           AW      = $clog2(DEPTH);
   localparam logic [7:0]   HOLD_M1 = 8'(HOLD_CYC - 1);
   localparam logic [7:0]   GAP_M1  = (GAP_CYC > 0) ? 8'(GAP_CYC - 1) : 8'd0;
   localparam bit           HAS_GAP = (GAP_CYC > 0);
   localparam logic [AW:0]  FULL    = (AW + 1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

   logic [1:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_cnt;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_hcnt;
   logic [7:0]    w_hcnt_nxt;
   logic [7:0]    r_gcnt;
   logic [7:0]    w_gcnt_nxt;
   logic [3:0]    r_o;
   logic [3:0]    w_o_nxt;
   logic          r_o_valid;
   logic          w_push;
   logic          w_pop;
   logic          w_empty;
   logic [3:0]    w_head_dec;

   // No pass-through: a full FIFO refuses input even on a cycle it is popped.
   assign in_ready   = (r_cnt < FULL);
   assign w_push     = in_valid && in_ready;
   assign w_empty    = (r_cnt == '0);
   assign w_head_dec = 4'b0001 << r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_hcnt    <= '0;
         r_gcnt    <= '0;
         r_o       <= '0;
         r_o_valid <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_hcnt    <= w_hcnt_nxt;
         r_gcnt    <= w_gcnt_nxt;
         r_o       <= w_o_nxt;
         r_o_valid <= (w_state_nxt == S_DRIVE);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hcnt_nxt  = r_hcnt;
      w_gcnt_nxt  = r_gcnt;
      w_o_nxt     = r_o;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_o_nxt = '0;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_o_nxt     = w_head_dec;
               w_hcnt_nxt  = HOLD_M1;
               w_state_nxt = S_DRIVE;
            end
         end
         S_DRIVE: begin
            if (r_hcnt != '0) begin
               w_hcnt_nxt = r_hcnt - 8'd1;
            end else if (HAS_GAP) begin
               w_o_nxt     = '0;
               w_gcnt_nxt  = GAP_M1;
               w_state_nxt = S_GAP;
            end else if (!w_empty) begin
               // Zero-gap mode chains codes back to back without leaving DRIVE.
               w_pop      = 1'b1;
               w_o_nxt    = w_head_dec;
               w_hcnt_nxt = HOLD_M1;
            end else begin
               w_o_nxt     = '0;
               w_state_nxt = S_IDLE;
            end
         end
         S_GAP: begin
            w_o_nxt = '0;
            if (r_gcnt != '0) begin
               w_gcnt_nxt = r_gcnt - 8'd1;
            end else if (!w_empty) begin
               w_pop       = 1'b1;
               w_o_nxt     = w_head_dec;
               w_hcnt_nxt  = HOLD_M1;
               w_state_nxt = S_DRIVE;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_o_nxt     = '0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o        = r_o;
   assign o_valid  = r_o_valid;
   assign busy     = (r_state != S_IDLE) || !w_empty;
   assign fifo_cnt = r_cnt;

endmodule

// File: tb/tb_decoder_24_seq.sv
// tb/tb_decoder_24_seq.sv - directed bench for decoder_24_seq (default and zero-gap instances).
module tb_decoder_24_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [1:0] in_code;
   logic [3:0] o;
   logic       o_valid;
   logic       busy;
   logic [2:0] fifo_cnt;

   logic       z_in_valid;
   logic       z_in_ready;
   logic [1:0] z_in_code;
   logic [3:0] z_o;
   logic       z_o_valid;
   logic       z_busy;
   logic [2:0] z_fifo_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0] mon_q[$];
   logic       mon_en   = 1'b0;
   logic       mon_prev = 1'b0;

   decoder_24_seq #(.HOLD_CYC(4), .GAP_CYC(1), .DEPTH(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_code  (in_code),
      .o        (o),
      .o_valid  (o_valid),
      .busy     (busy),
      .fifo_cnt (fifo_cnt)
   );

   decoder_24_seq #(.HOLD_CYC(1), .GAP_CYC(0), .DEPTH(4)) dut_z (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (z_in_valid),
      .in_ready (z_in_ready),
      .in_code  (z_in_code),
      .o        (z_o),
      .o_valid  (z_o_valid),
      .busy     (z_busy),
      .fifo_cnt (z_fifo_cnt)
   );

   always #5 clk = ~clk;

   // Records each new one-hot word as o_valid rises.
   always @(negedge clk) begin
      if (mon_en && o_valid && !mon_prev) mon_q.push_back(o);
      mon_prev = o_valid;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_o(input string tag, input logic [3:0] exp, input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, {28'd0, o}, {28'd0, exp});
         chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, (exp != 4'b0000)});
      end
   endtask

   task automatic wait_idle(input string tag);
      int k;
      k = 0;
      while (busy && k < 200) begin
         tick();
         k++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   logic [1:0] bp_codes [6];

   initial begin
      bp_codes[0] = 2'd3; bp_codes[1] = 2'd1; bp_codes[2] = 2'd0;
      bp_codes[3] = 2'd2; bp_codes[4] = 2'd2; bp_codes[5] = 2'd1;

      rst_n      = 1'b0;
      in_valid   = 1'b1;
      in_code    = 2'd3;
      z_in_valid = 1'b0;
      z_in_code  = 2'd0;
      tick();
      tick();
      chk("rst_o", {28'd0, o}, 32'd0);
      chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_fifo_cnt", {29'd0, fifo_cnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      chk("post_rst_cnt", {29'd0, fifo_cnt}, 32'd0);

      // Single code
      in_valid = 1'b1;
      in_code  = 2'd2;
      tick();
      in_valid = 1'b0;
      chk("single_cnt", {29'd0, fifo_cnt}, 32'd1);
      chk("single_o_lat", {28'd0, o}, 32'd0);
      chk("single_busy", {31'd0, busy}, 32'd1);
      expect_o("single_hold", 4'b0100, 4);
      chk("single_busy_last", {31'd0, busy}, 32'd1);
      expect_o("single_gap", 4'b0000, 1);
      chk("single_busy_gap", {31'd0, busy}, 32'd1);
      tick();
      chk("single_busy_idle", {31'd0, busy}, 32'd0);
      chk("single_o_idle", {28'd0, o}, 32'd0);

      // Burst of four codes back to back
      in_valid = 1'b1;
      in_code  = 2'd0;
      chk("burst_rdy0", {31'd0, in_ready}, 32'd1);
      tick();
      chk("burst_o0", {28'd0, o}, 32'd0);
      in_code = 2'd1;
      chk("burst_rdy1", {31'd0, in_ready}, 32'd1);
      tick();
      chk("burst_o1", {28'd0, o}, 32'h1);
      in_code = 2'd2;
      chk("burst_rdy2", {31'd0, in_ready}, 32'd1);
      tick();
      chk("burst_o2", {28'd0, o}, 32'h1);
      in_code = 2'd3;
      chk("burst_rdy3", {31'd0, in_ready}, 32'd1);
      tick();
      chk("burst_o3", {28'd0, o}, 32'h1);
      chk("burst_cnt", {29'd0, fifo_cnt}, 32'd3);
      in_valid = 1'b0;
      expect_o("burst_h0", 4'b0001, 1);
      expect_o("burst_g0", 4'b0000, 1);
      expect_o("burst_h1", 4'b0010, 4);
      expect_o("burst_g1", 4'b0000, 1);
      expect_o("burst_h2", 4'b0100, 4);
      expect_o("burst_g2", 4'b0000, 1);
      expect_o("burst_h3", 4'b1000, 4);
      expect_o("burst_end", 4'b0000, 2);
      chk("burst_busy", {31'd0, busy}, 32'd0);

      // Backpressure, including a rejected push on a full-and-popping cycle
      mon_q.delete();
      mon_en   = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_code = bp_codes[i];
         chk("bp_rdy", {31'd0, in_ready}, 32'd1);
         tick();
      end
      chk("bp_full_cnt", {29'd0, fifo_cnt}, 32'd4);
      chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
      in_code = bp_codes[5];
      tick();
      chk("bp_gap_cnt", {29'd0, fifo_cnt}, 32'd4);
      chk("bp_gap_o", {28'd0, o}, 32'd0);
      tick();
      chk("bp_pop_cnt", {29'd0, fifo_cnt}, 32'd3);
      chk("bp_pop_rdy", {31'd0, in_ready}, 32'd1);
      chk("bp_pop_o", {28'd0, o}, {28'd0, 4'b0010});
      tick();
      in_valid = 1'b0;
      chk("bp_accept_cnt", {29'd0, fifo_cnt}, 32'd4);
      wait_idle("bp_drain");
      tick();
      mon_en = 1'b0;
      chk("bp_count", mon_q.size(), 32'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < mon_q.size())
            chk("bp_order", {28'd0, mon_q[i]}, {28'd0, 4'b0001 << bp_codes[i]});
      end

      // Reset during the second hold cycle with two codes queued
      in_valid = 1'b1;
      in_code  = 2'd2;
      tick();
      in_code = 2'd1;
      tick();
      in_code = 2'd3;
      tick();
      in_valid = 1'b0;
      chk("mid_o_pre", {28'd0, o}, {28'd0, 4'b0100});
      chk("mid_cnt_pre", {29'd0, fifo_cnt}, 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_o_async", {28'd0, o}, 32'd0);
      chk("mid_cnt_async", {29'd0, fifo_cnt}, 32'd0);
      chk("mid_valid_async", {31'd0, o_valid}, 32'd0);
      tick();
      rst_n = 1'b1;
      expect_o("mid_quiet", 4'b0000, 8);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      in_valid = 1'b1;
      in_code  = 2'd1;
      tick();
      in_valid = 1'b0;
      chk("mid_new_lat", {28'd0, o}, 32'd0);
      expect_o("mid_new", 4'b0010, 4);
      wait_idle("mid_drain");

      // Zero-gap instance: codes chained with no zero cycle
      z_in_valid = 1'b1;
      z_in_code  = 2'd3;
      tick();
      chk("z_o0", {28'd0, z_o}, 32'd0);
      z_in_code = 2'd0;
      tick();
      chk("z_o1", {28'd0, z_o}, {28'd0, 4'b1000});
      z_in_code = 2'd1;
      tick();
      z_in_valid = 1'b0;
      chk("z_o2", {28'd0, z_o}, {28'd0, 4'b0001});
      chk("z_v2", {31'd0, z_o_valid}, 32'd1);
      tick();
      chk("z_o3", {28'd0, z_o}, {28'd0, 4'b0010});
      tick();
      chk("z_o4", {28'd0, z_o}, 32'd0);
      chk("z_v4", {31'd0, z_o_valid}, 32'd0);
      chk("z_busy", {31'd0, z_busy}, 32'd0);
      chk("z_rdy", {31'd0, z_in_ready}, 32'd1);
      chk("z_cnt", {29'd0, z_fifo_cnt}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
